pll_reset_sequencer: RTL and testbench

//  Sits directly downstream of the system PLL, clocked by one PLL output clock.

---
 rtl/pll_rst_pkg.sv | 22 ++
 rtl/lock_sync.sv | 27 ++
 rtl/pll_reset_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Sequencer states, lock-loss counter width and the state-counter width helper.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    StWaitLock,
    StStabilize,
    StRelCore,
    StRun,
    StHold
  } rst_state_t;

  localparam int unsigned LOSS_CNT_W = 8;

  // Wide enough to hold max(a, b) without wrapping.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lock_sync.sv
// Multi-flop synchroniser that brings the raw PLL lock flag into the clk domain.
module lock_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lock_raw_i,
  output logic lock_s_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], lock_raw_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign lock_s_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the core in reset until PLL lock is stable, releases core then CPU reset and
// generates aligned pixel/CPU clock enables. Optional LOCK_LOSS_COUNT_EN adds lock_loss_cnt.
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned STAGE_GAP     = 64,
  parameter int unsigned PIX_DIV       = 4,
  parameter int unsigned CPU_DIV       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  soft_rst,
  output logic                  core_rst_n,
  output logic                  cpu_rst_n,
  output logic                  ce_pix,
  output logic                  ce_cpu,
  output logic                  ready
`ifdef LOCK_LOSS_COUNT_EN
  ,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
`endif
);

  localparam int unsigned CntW = cnt_width(STABLE_CYCLES, STAGE_GAP);
  localparam int unsigned DivW = $clog2(CPU_DIV);
  localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast    = CntW'(STAGE_GAP - 1);
  localparam logic [DivW-1:0] DivLast    = DivW'(CPU_DIV - 1);

  if (CPU_DIV % PIX_DIV != 0) begin : g_bad_div_ratio
    $error("CPU_DIV must be a multiple of PIX_DIV");
  end
  if (PIX_DIV < 2) begin : g_bad_pix_div
    $error("PIX_DIV must be at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be at least 2");
  end

  logic lock_s;

  lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .lock_raw_i (pll_locked),
    .lock_s_o   (lock_s)
  );

  rst_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DivW-1:0] div_q, div_d;
  logic            core_rst_n_q, core_rst_n_d;
  logic            cpu_rst_n_q, cpu_rst_n_d;
  logic            ready_q, ready_d;
  logic            ce_pix_q, ce_pix_d;
  logic            ce_cpu_q, ce_cpu_d;
  logic            div_run;
`ifdef LOCK_LOSS_COUNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef LOCK_LOSS_COUNT_EN
    loss_cnt_d = loss_cnt_q;
`endif

    // Lock loss outranks soft reset and normal progression.
    if (state_q != StWaitLock && !lock_s) begin
      state_d = StWaitLock;
      cnt_d   = '0;
`ifdef LOCK_LOSS_COUNT_EN
      if (loss_cnt_q != {LOSS_CNT_W{1'b1}}) begin
        loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
      end
`endif
    end else begin
      unique case (state_q)
        StWaitLock: begin
          if (lock_s) begin
            state_d = StStabilize;
            cnt_d   = '0;
          end
        end
        StStabilize: begin
          if (soft_rst) begin
            state_d = StHold;
            cnt_d   = '0;
          end else if (cnt_q == StableLast) begin
            state_d = StRelCore;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StRelCore: begin
          if (soft_rst) begin
            state_d = StHold;
            cnt_d   = '0;
          end else if (cnt_q == GapLast) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StRun: begin
          if (soft_rst) begin
            state_d = StHold;
            cnt_d   = '0;
          end
        end
        StHold: begin
          // Lock was held throughout, so skip straight to the core release.
          if (!soft_rst) begin
            state_d = StRelCore;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      endcase
    end

    core_rst_n_d = (state_d == StRelCore) || (state_d == StRun);
    cpu_rst_n_d  = (state_d == StRun);
    ready_d      = (state_d == StRun);

    // Divider runs only while core reset is released and stays released.
    div_run = core_rst_n_q && core_rst_n_d;
    div_d   = '0;
    if (div_run) begin
      div_d = (div_q == DivLast) ? '0 : div_q + DivW'(1);
    end
    ce_pix_d = div_run && ((32'(div_q) % PIX_DIV) == (PIX_DIV - 1));
    ce_cpu_d = div_run && (div_q == DivLast);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StWaitLock;
      cnt_q        <= '0;
      div_q        <= '0;
      core_rst_n_q <= 1'b0;
      cpu_rst_n_q  <= 1'b0;
      ready_q      <= 1'b0;
      ce_pix_q     <= 1'b0;
      ce_cpu_q     <= 1'b0;
`ifdef LOCK_LOSS_COUNT_EN
      loss_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      core_rst_n_q <= core_rst_n_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      ready_q      <= ready_d;
      ce_pix_q     <= ce_pix_d;
      ce_cpu_q     <= ce_cpu_d;
`ifdef LOCK_LOSS_COUNT_EN
      loss_cnt_q   <= loss_cnt_d;
`endif
    end
  end

  assign core_rst_n = core_rst_n_q;
  assign cpu_rst_n  = cpu_rst_n_q;
  assign ready      = ready_q;
  assign ce_pix     = ce_pix_q;
  assign ce_cpu     = ce_cpu_q;
`ifdef LOCK_LOSS_COUNT_EN
  assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: constant vector table, directed corner sequences and
// randomized lock/soft-reset stimulus against a timestamp-based reference model.
module tb_pll_reset_sequencer;

  localparam int unsigned N = 2;  // SYNC_STAGES
  localparam int unsigned S = 8;  // STABLE_CYCLES
  localparam int unsigned G = 4;  // STAGE_GAP
  localparam int unsigned P = 2;  // PIX_DIV
  localparam int unsigned C = 4;  // CPU_DIV

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0;
  logic soft_rst = 1'b0;
  logic core_rst_n, cpu_rst_n, ce_pix, ce_cpu, ready;
  logic [4:0] dut_vec;
`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .SYNC_STAGES  (N),
    .STABLE_CYCLES(S),
    .STAGE_GAP    (G),
    .PIX_DIV      (P),
    .CPU_DIV      (C)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .soft_rst     (soft_rst),
    .core_rst_n   (core_rst_n),
    .cpu_rst_n    (cpu_rst_n),
    .ce_pix       (ce_pix),
    .ce_cpu       (ce_cpu),
    .ready        (ready)
`ifdef LOCK_LOSS_COUNT_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  assign dut_vec = {core_rst_n, cpu_rst_n, ready, ce_pix, ce_cpu};

  int total = 0;
  int bad = 0;
  int ecnt = 0;

  // Reference model: tracks how long synced lock has been continuously high and the
  // edge at which core reset was released; all outputs follow from elapsed time.
  logic hist[$];
  int   lock_run;
  bit   held;
  bit   core_on;
  int   rel_edge;
  int   loss_m;
  logic [4:0] exp_vec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", name, ecnt, act, want);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    lock_run = 0;
    held     = 1'b0;
    core_on  = 1'b0;
    rel_edge = 0;
    loss_m   = 0;
    exp_vec  = '0;
  endtask

  task automatic model_step(input logic lk, input logic sr);
    logic ls;
    int   prev;
    int   dt;
    ls = (hist.size() >= N) ? hist[hist.size() - N] : 1'b0;
    hist.push_back(lk);
    if (hist.size() > N) void'(hist.pop_front());
    if (!ls) begin
      if (lock_run > 0 && loss_m < 255) loss_m++;
      lock_run = 0;
      held     = 1'b0;
      core_on  = 1'b0;
    end else begin
      prev = lock_run;
      if (lock_run < 1000) lock_run++;
      if (sr && prev > 0) begin
        held    = 1'b1;
        core_on = 1'b0;
      end else if (held) begin
        held     = 1'b0;
        core_on  = 1'b1;
        rel_edge = ecnt;
      end else if (!core_on && lock_run == S + 1) begin
        core_on  = 1'b1;
        rel_edge = ecnt;
      end
    end
    dt = ecnt - rel_edge;
    exp_vec[4] = core_on;
    exp_vec[3] = core_on && dt >= G;
    exp_vec[2] = core_on && dt >= G;
    exp_vec[1] = core_on && dt > 0 && (dt % P) == 0;
    exp_vec[0] = core_on && dt > 0 && (dt % C) == 0;
  endtask

  task automatic tick(input logic lk, input logic sr);
    pll_locked = lk;
    soft_rst   = sr;
    @(posedge clk);
    ecnt++;
    model_step(lk, sr);
    #1;
    chk("model_outputs", 32'(dut_vec), 32'(exp_vec));
`ifdef LOCK_LOSS_COUNT_EN
    chk("model_loss_cnt", 32'(lock_loss_cnt), 32'(loss_m));
`endif
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    soft_rst   = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(dut_vec), 32'h0);
`ifdef LOCK_LOSS_COUNT_EN
    chk("async_reset_loss_cnt", 32'(lock_loss_cnt), 32'h0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ecnt  = 0;
  endtask

  typedef struct packed {
    logic       lk;
    logic       sr;
    logic [4:0] want;  // {core_rst_n, cpu_rst_n, ready, ce_pix, ce_cpu}
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic lk, sr;
    int   len;

    // Power-up lock at cycle 0: core at edge 11, cpu/ready at 15, ce_pix from 13, ce_cpu from 15.
    for (int i = 0; i < 10; i++) tbl[i] = '{lk: 1'b1, sr: 1'b0, want: 5'b00000};
    tbl[10] = '{lk: 1'b1, sr: 1'b0, want: 5'b10000};
    tbl[11] = '{lk: 1'b1, sr: 1'b0, want: 5'b10000};
    tbl[12] = '{lk: 1'b1, sr: 1'b0, want: 5'b10010};
    tbl[13] = '{lk: 1'b1, sr: 1'b0, want: 5'b10000};
    tbl[14] = '{lk: 1'b1, sr: 1'b0, want: 5'b11111};
    tbl[15] = '{lk: 1'b1, sr: 1'b0, want: 5'b11100};
    tbl[16] = '{lk: 1'b1, sr: 1'b0, want: 5'b11110};
    tbl[17] = '{lk: 1'b1, sr: 1'b0, want: 5'b11100};
    tbl[18] = '{lk: 1'b1, sr: 1'b0, want: 5'b11111};
    tbl[19] = '{lk: 1'b1, sr: 1'b0, want: 5'b11100};

    apply_reset();
    for (int i = 0; i < 20; i++) begin
      tick(tbl[i].lk, tbl[i].sr);
      chk("table", 32'(dut_vec), 32'(tbl[i].want));
    end

    // Lock glitch seen while stabilising: restart, release only after full re-stabilisation.
    apply_reset();
    for (int e = 1; e <= 22; e++) begin
      tick((e >= 6 && e <= 8) ? 1'b0 : 1'b1, 1'b0);
      chk("glitch_core_rst_n", 32'(core_rst_n), 32'(e >= 19));
    end

    // Lock loss in RUN: outputs drop three edges after the raw drop, then re-lock.
    apply_reset();
    for (int e = 1; e <= 40; e++) begin
      tick((e >= 21 && e <= 25) ? 1'b0 : 1'b1, 1'b0);
      if (e == 22) chk("loss_core_still_up", 32'(core_rst_n), 32'h1);
      if (e == 23) chk("loss_all_low", 32'(dut_vec), 32'h0);
`ifdef LOCK_LOSS_COUNT_EN
      if (e == 23) chk("loss_cnt_one", 32'(lock_loss_cnt), 32'h1);
`endif
      if (e == 35) chk("relock_core_low", 32'(core_rst_n), 32'h0);
      if (e == 36) chk("relock_core_high", 32'(core_rst_n), 32'h1);
      if (e == 40) chk("relock_ready", 32'(ready), 32'h1);
    end

    // Soft reset for 5 cycles in RUN.
    apply_reset();
    for (int e = 1; e <= 32; e++) begin
      tick(1'b1, (e >= 21 && e <= 25) ? 1'b1 : 1'b0);
      if (e == 21) chk("soft_resets_low", 32'({core_rst_n, cpu_rst_n}), 32'h0);
      if (e == 25) chk("soft_core_held", 32'(core_rst_n), 32'h0);
      if (e == 26) chk("soft_core_release", 32'({core_rst_n, cpu_rst_n}), 32'h2);
      if (e == 29) chk("soft_cpu_not_yet", 32'(cpu_rst_n), 32'h0);
      if (e == 30) chk("soft_cpu_release", 32'(cpu_rst_n), 32'h1);
    end

    // Soft reset and lock loss in the same cycle: lock loss wins, full stabilisation needed.
    apply_reset();
    for (int e = 1; e <= 34; e++) begin
      tick((e == 21) ? 1'b0 : 1'b1, (e == 23) ? 1'b1 : 1'b0);
      if (e >= 23) chk("soft_and_loss_core", 32'(core_rst_n), 32'(e >= 32));
    end

    // rst_n pulse while in REL_CORE, then a clean restart.
    apply_reset();
    for (int e = 1; e <= 12; e++) tick(1'b1, 1'b0);
    chk("rel_core_before_reset", 32'(core_rst_n), 32'h1);
    apply_reset();
    for (int e = 1; e <= 11; e++) begin
      tick(1'b1, 1'b0);
      if (e == 11) chk("restart_core_release", 32'(core_rst_n), 32'h1);
    end

    // 300 lock toggles: loss counter saturates.
    apply_reset();
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
`ifdef LOCK_LOSS_COUNT_EN
    chk("loss_cnt_saturated", 32'(lock_loss_cnt), 32'd255);
`endif
    chk("toggle_end_outputs", 32'(dut_vec), 32'h0);

    // Randomized lock runs and soft reset bursts.
    apply_reset();
    sr = 1'b0;
    for (int s = 0; s < 80; s++) begin
      lk  = (s % 2 == 0) ? 1'b1 : 1'b0;
      len = lk ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) == 0) sr = ~sr;
        tick(lk, sr);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
